pipe_shifter: RTL and testbench

- Parametrised, pipelined barrel shifter. Successor to the single-cycle 32-bit shift unit.
- Supports a generic operand width and a selectable number of pipeline register stages.
- Adds rotate-right, valid/ready handshakes with backpressure, and a sideband tag carried alongside each operation.
- Sits in the EX stage of the pipelined CPU, or behind a multi-cycle ALU issue port.

---
 rtl/pipe_shifter_pkg.sv | 24 ++
 rtl/pipe_shifter_level.sv | 28 ++
 rtl/pipe_shifter.sv | 145 ++++++++++++++
 tb/tb_pipe_shifter.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_shifter_pkg.sv
// Shared shift-mode encodings and elaboration-time helpers for the pipelined shifter.
// Pure definitions; no logic, no latency.
package pipe_shifter_pkg;

   localparam logic [1:0] MODE_SLL = 2'b00;
   localparam logic [1:0] MODE_SRL = 2'b01;
   localparam logic [1:0] MODE_ROR = 2'b10;
   localparam logic [1:0] MODE_SRA = 2'b11;

   function automatic int f_log2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

   // Pipeline stage that owns shift level lvl.
   function automatic int f_stage_of(input int lvl, input int stages, input int levels);
      return (lvl * stages) / levels;
   endfunction

endpackage

// File: rtl/pipe_shifter_level.sv
// One fixed-distance shift/rotate level; purely combinational, zero latency, no handshake.
// SRA fill comes from the operand's original MSB, supplied by the caller.
module shift_level
   import pipe_shifter_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DIST  = 1
) (
   input  logic [WIDTH-1:0] data,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic             sign,
   output logic [WIDTH-1:0] shifted
);

   always_comb begin
      shifted = data;
      if (en) begin
         case (mode)
            MODE_SLL: shifted = {data[WIDTH-DIST-1:0], {DIST{1'b0}}};
            MODE_SRL: shifted = {{DIST{1'b0}}, data[WIDTH-1:DIST]};
            MODE_SRA: shifted = {{DIST{sign}}, data[WIDTH-1:DIST]};
            default:  shifted = {data[DIST-1:0], data[WIDTH-1:DIST]};
         endcase
      end
   end

endmodule

// File: rtl/pipe_shifter.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROR) with sideband tag; latency STAGES cycles, 1 op/cycle.
// Valid/ready per stage: empty stages absorb bubbles, a stalled output holds and back-fills to STAGES entries.
module pipe_shifter
   import pipe_shifter_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int STAGES = 1,
   parameter int TAG_W  = 5
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [WIDTH-1:0]          in_data,
   input  logic [f_log2(WIDTH)-1:0]  in_amt,
   input  logic [1:0]                in_mode,
   input  logic [TAG_W-1:0]          in_tag,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [WIDTH-1:0]          out_data,
   output logic [TAG_W-1:0]          out_tag
);

   localparam int LEVELS = f_log2(WIDTH);

   logic [STAGES-1:0] r_vld;
   logic [WIDTH-1:0]  r_dat  [STAGES];
   logic [TAG_W-1:0]  r_tag  [STAGES];
   logic [1:0]        r_mode [STAGES];
   logic [LEVELS-1:0] r_amt  [STAGES];
   logic [STAGES-1:0] r_sign;

   logic [WIDTH-1:0]  w_si_dat  [STAGES];
   logic [TAG_W-1:0]  w_si_tag  [STAGES];
   logic [1:0]        w_si_mode [STAGES];
   logic [LEVELS-1:0] w_si_amt  [STAGES];
   logic [STAGES-1:0] w_si_sign;
   logic [WIDTH-1:0]  w_stage_out [STAGES];

   logic [STAGES-1:0] w_rdy;
   logic [STAGES-1:0] w_load;
   logic [STAGES-1:0] w_adv;

   for (genvar k = 0; k < STAGES; k++) begin : g_src
      if (k == 0) begin : g_in
         assign w_si_dat[k]  = in_data;
         assign w_si_tag[k]  = in_tag;
         assign w_si_mode[k] = in_mode;
         assign w_si_amt[k]  = in_amt;
         assign w_si_sign[k] = in_data[WIDTH-1];
      end else begin : g_reg
         assign w_si_dat[k]  = r_dat[k-1];
         assign w_si_tag[k]  = r_tag[k-1];
         assign w_si_mode[k] = r_mode[k-1];
         assign w_si_amt[k]  = r_amt[k-1];
         assign w_si_sign[k] = r_sign[k-1];
      end
   end

   // Levels chain within a stage; a stage boundary restarts from the previous stage's register.
   for (genvar i = 0; i < LEVELS; i++) begin : g_lvl
      localparam int  S     = f_stage_of(i, STAGES, LEVELS);
      localparam bit  FIRST = (i == 0) || (f_stage_of(i - 1, STAGES, LEVELS) != S);
      localparam bit  LAST  = (i == LEVELS - 1) || (f_stage_of(i + 1, STAGES, LEVELS) != S);
      logic [WIDTH-1:0] w_in;
      logic [WIDTH-1:0] w_out;

      if (FIRST) begin : g_first
         assign w_in = w_si_dat[S];
      end else begin : g_chain
         assign w_in = g_lvl[i-1].w_out;
      end

      shift_level #(.WIDTH(WIDTH), .DIST(WIDTH >> (i + 1))) u_level (
         .data    (w_in),
         .en      (w_si_amt[S][LEVELS-1-i]),
         .mode    (w_si_mode[S]),
         .sign    (w_si_sign[S]),
         .shifted (w_out)
      );

      if (LAST) begin : g_last
         assign w_stage_out[S] = w_out;
      end
   end

   // A stage can take new data if it is empty or its content moves on this cycle.
   always_comb begin
      logic v_rdy;
      v_rdy = out_ready;
      w_rdy = '0;
      for (int k = STAGES - 1; k >= 0; k--) begin
         v_rdy    = !r_vld[k] || v_rdy;
         w_rdy[k] = v_rdy;
      end
   end

   always_comb begin
      w_load = '0;
      w_adv  = '0;
      w_load[0] = in_valid && w_rdy[0];
      for (int k = 1; k < STAGES; k++) begin
         w_load[k] = r_vld[k-1] && w_rdy[k];
      end
      for (int k = 0; k < STAGES - 1; k++) begin
         w_adv[k] = r_vld[k] && w_rdy[k+1];
      end
      w_adv[STAGES-1] = r_vld[STAGES-1] && out_ready;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_vld  <= '0;
         r_sign <= '0;
         for (int k = 0; k < STAGES; k++) begin
            r_dat[k]  <= '0;
            r_tag[k]  <= '0;
            r_mode[k] <= '0;
            r_amt[k]  <= '0;
         end
      end else begin
         for (int k = 0; k < STAGES; k++) begin
            if (w_load[k]) begin
               r_vld[k]  <= 1'b1;
               r_dat[k]  <= w_stage_out[k];
               r_tag[k]  <= w_si_tag[k];
               r_mode[k] <= w_si_mode[k];
               r_amt[k]  <= w_si_amt[k];
               r_sign[k] <= w_si_sign[k];
            end else if (w_adv[k]) begin
               r_vld[k]  <= 1'b0;
            end
         end
      end
   end

   logic w_unused;
   assign w_unused = ^{r_mode[STAGES-1], r_amt[STAGES-1], r_sign[STAGES-1]};

   assign in_ready  = w_rdy[0];
   assign out_valid = r_vld[STAGES-1];
   assign out_data  = r_dat[STAGES-1];
   assign out_tag   = r_tag[STAGES-1];

endmodule

// File: tb/tb_pipe_shifter.sv
// Bench for pipe_shifter: three configurations (32/1, 32/3, 16/4) checked against a queue scoreboard
// fed by a behavioural shift model, plus stall, latency and asynchronous-reset scenarios.
module tb_pipe_shifter;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0h expected %0h", nm, got, exp);
      end
   endtask

   function automatic logic [31:0] model(input logic [31:0] d, input int amt,
                                        input logic [1:0] m, input int w);
      logic [63:0] mask, x, r;
      mask = (64'd1 << w) - 64'd1;
      x = {32'd0, d} & mask;
      case (m)
         2'b00: r = (x << amt) & mask;
         2'b01: r = x >> amt;
         2'b11: begin
            r = x >> amt;
            if (x[w-1]) r = r | (mask & ~(mask >> amt));
         end
         default: r = ((x >> amt) | (x << (w - amt))) & mask;
      endcase
      return r[31:0];
   endfunction

   // Instance A: WIDTH 32, STAGES 1
   logic        a_iv = 1'b0, a_or = 1'b1, a_ir, a_ov;
   logic [31:0] a_id = '0, a_od;
   logic [4:0]  a_am = '0, a_it = '0, a_ot;
   logic [1:0]  a_md = '0;
   // Instance B: WIDTH 32, STAGES 3
   logic        b_iv = 1'b0, b_or = 1'b1, b_ir, b_ov;
   logic [31:0] b_id = '0, b_od;
   logic [4:0]  b_am = '0, b_it = '0, b_ot;
   logic [1:0]  b_md = '0;
   // Instance C: WIDTH 16, STAGES 4
   logic        c_iv = 1'b0, c_or = 1'b1, c_ir, c_ov;
   logic [15:0] c_id = '0, c_od;
   logic [3:0]  c_am = '0;
   logic [4:0]  c_it = '0, c_ot;
   logic [1:0]  c_md = '0;

   pipe_shifter #(.WIDTH(32), .STAGES(1), .TAG_W(5)) u_a (
      .clk(clk), .reset(reset), .in_valid(a_iv), .in_ready(a_ir), .in_data(a_id),
      .in_amt(a_am), .in_mode(a_md), .in_tag(a_it), .out_valid(a_ov), .out_ready(a_or),
      .out_data(a_od), .out_tag(a_ot));
   pipe_shifter #(.WIDTH(32), .STAGES(3), .TAG_W(5)) u_b (
      .clk(clk), .reset(reset), .in_valid(b_iv), .in_ready(b_ir), .in_data(b_id),
      .in_amt(b_am), .in_mode(b_md), .in_tag(b_it), .out_valid(b_ov), .out_ready(b_or),
      .out_data(b_od), .out_tag(b_ot));
   pipe_shifter #(.WIDTH(16), .STAGES(4), .TAG_W(5)) u_c (
      .clk(clk), .reset(reset), .in_valid(c_iv), .in_ready(c_ir), .in_data(c_id),
      .in_amt(c_am), .in_mode(c_md), .in_tag(c_it), .out_valid(c_ov), .out_ready(c_or),
      .out_data(c_od), .out_tag(c_ot));

   typedef struct {
      logic [31:0] d;
      logic [4:0]  t;
      int          c;
   } exp_t;

   exp_t qa[$], qb[$], qc[$];
   exp_t ea, eb, ec;
   bit   lat_b = 1'b1;

   always @(negedge clk) begin
      if (reset) begin
         if (a_ov && a_or) begin
            if (qa.size() == 0) chk("a_extra", 64'(1), 64'(0));
            else begin
               ea = qa.pop_front();
               chk("a_data", 64'(a_od), 64'(ea.d));
               chk("a_tag", 64'(a_ot), 64'(ea.t));
               chk("a_lat", 64'(cyc - ea.c), 64'(1));
            end
         end
         if (a_iv && a_ir) qa.push_back('{model(a_id, int'(a_am), a_md, 32), a_it, cyc});

         if (b_ov && b_or) begin
            if (qb.size() == 0) chk("b_extra", 64'(1), 64'(0));
            else begin
               eb = qb.pop_front();
               chk("b_data", 64'(b_od), 64'(eb.d));
               chk("b_tag", 64'(b_ot), 64'(eb.t));
               if (lat_b) chk("b_lat", 64'(cyc - eb.c), 64'(3));
            end
         end
         if (b_iv && b_ir) qb.push_back('{model(b_id, int'(b_am), b_md, 32), b_it, cyc});

         if (c_ov && c_or) begin
            if (qc.size() == 0) chk("c_extra", 64'(1), 64'(0));
            else begin
               ec = qc.pop_front();
               chk("c_data", 64'(c_od), 64'(ec.d));
               chk("c_tag", 64'(c_ot), 64'(ec.t));
               chk("c_lat", 64'(cyc - ec.c), 64'(4));
            end
         end
         if (c_iv && c_ir) qc.push_back('{model({16'd0, c_id}, int'(c_am), c_md, 16), c_it, cyc});
      end
   end

   task automatic send_a(input logic [31:0] d, input int amt, input logic [1:0] m, input logic [4:0] t);
      int n = 0;
      a_id = d; a_am = 5'(amt); a_md = m; a_it = t; a_iv = 1'b1;
      do begin @(negedge clk); n++; end while (!a_ir && n < 20);
      if (!a_ir) chk("a_accept_timeout", 64'(0), 64'(1));
      @(posedge clk); #1 a_iv = 1'b0;
   endtask

   task automatic send_b(input logic [31:0] d, input int amt, input logic [1:0] m, input logic [4:0] t);
      int n = 0;
      b_id = d; b_am = 5'(amt); b_md = m; b_it = t; b_iv = 1'b1;
      do begin @(negedge clk); n++; end while (!b_ir && n < 20);
      if (!b_ir) chk("b_accept_timeout", 64'(0), 64'(1));
      @(posedge clk); #1 b_iv = 1'b0;
   endtask

   task automatic send_c(input logic [15:0] d, input int amt, input logic [1:0] m, input logic [4:0] t);
      int n = 0;
      c_id = d; c_am = 4'(amt); c_md = m; c_it = t; c_iv = 1'b1;
      do begin @(negedge clk); n++; end while (!c_ir && n < 20);
      if (!c_ir) chk("c_accept_timeout", 64'(0), 64'(1));
      @(posedge clk); #1 c_iv = 1'b0;
   endtask

   task automatic wait_drain(input string nm);
      int n = 0;
      while ((qa.size() + qb.size() + qc.size()) != 0 && n < 100) begin
         @(negedge clk); n++;
      end
      @(negedge clk);
      chk(nm, 64'(qa.size() + qb.size() + qc.size()), 64'(0));
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int          acc;
      bit          snap;
      logic [31:0] sd;
      logic [4:0]  st;

      #1;
      chk("rst_a_ov", 64'(a_ov), 64'(0));
      chk("rst_a_od", 64'(a_od), 64'(0));
      chk("rst_a_ot", 64'(a_ot), 64'(0));
      chk("rst_b_ov", 64'(b_ov), 64'(0));
      chk("rst_c_od", 64'(c_od), 64'(0));
      #11 reset = 1'b1;
      @(posedge clk); #1;
      chk("rst_a_ir", 64'(a_ir), 64'(1));
      chk("rst_b_ir", 64'(b_ir), 64'(1));
      chk("rst_c_ir", 64'(c_ir), 64'(1));

      // Directed vectors, amount-0 in every mode, then random ops.
      send_a(32'h0000_0001, 31, 2'b00, 5'd1);
      send_a(32'h8000_0000, 31, 2'b01, 5'd2);
      send_a(32'h8000_0000, 4, 2'b11, 5'd3);
      send_a(32'h7FFF_FFFF, 4, 2'b11, 5'd4);
      send_a(32'h0000_00F1, 4, 2'b10, 5'd5);
      for (int m = 0; m < 4; m++) send_a(32'hA5C3_0F96, 0, 2'(m), 5'(6 + m));
      for (int i = 0; i < 20; i++)
         send_a($urandom, $urandom_range(0, 31), 2'($urandom_range(0, 3)), 5'(i));
      send_c(16'h0001, 15, 2'b00, 5'd1);
      send_c(16'h1234, 8, 2'b10, 5'd2);
      send_c(16'h8421, 3, 2'b11, 5'd3);
      for (int i = 0; i < 20; i++)
         send_c(16'($urandom), $urandom_range(0, 15), 2'($urandom_range(0, 3)), 5'(i));
      wait_drain("drain_ac");

      // Back-to-back burst on the 3-stage pipe, tags 0..7.
      for (int i = 0; i < 8; i++)
         send_b($urandom, $urandom_range(0, 31), 2'($urandom_range(0, 3)), 5'(i));
      wait_drain("drain_burst");

      // Output stalled for 6 cycles with input always offered.
      lat_b = 1'b0; b_or = 1'b0; acc = 0; snap = 1'b0; sd = '0; st = '0;
      for (int i = 0; i < 6; i++) begin
         b_id = $urandom; b_am = 5'($urandom_range(0, 31));
         b_md = 2'($urandom_range(0, 3)); b_it = 5'(16 + i); b_iv = 1'b1;
         @(negedge clk);
         if (b_ir) acc++;
         if (b_ov && !snap) begin snap = 1'b1; sd = b_od; st = b_ot; end
         @(posedge clk); #1;
      end
      b_iv = 1'b0;
      @(negedge clk);
      chk("stall_accepted", 64'(acc), 64'(3));
      chk("stall_in_ready", 64'(b_ir), 64'(0));
      chk("stall_out_valid", 64'(b_ov), 64'(1));
      chk("stall_data_hold", 64'(b_od), 64'(sd));
      chk("stall_tag_hold", 64'(b_ot), 64'(st));
      @(posedge clk); #1 b_or = 1'b1;
      wait_drain("drain_stall");

      // Asynchronous reset with two ops in flight.
      b_or = 1'b0;
      send_b(32'h1234_5678, 8, 2'b10, 5'd20);
      send_b(32'h8765_4321, 4, 2'b11, 5'd21);
      repeat (3) @(posedge clk);
      #3;
      chk("pre_reset_out_valid", 64'(b_ov), 64'(1));
      reset = 1'b0;
      #1;
      chk("async_rst_out_valid", 64'(b_ov), 64'(0));
      chk("async_rst_out_data", 64'(b_od), 64'(0));
      chk("async_rst_out_tag", 64'(b_ot), 64'(0));
      qb.delete();
      @(posedge clk); #1;
      reset = 1'b1; b_or = 1'b1; lat_b = 1'b1;
      send_b(32'hF000_000F, 4, 2'b10, 5'd9);
      wait_drain("drain_after_reset");

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
